mp_core_initiator: RTL and testbench
====================================

Name: mp_core_initiator

Overview:
- Per-core request initiator for the multiprocessor memory subsystem (mp_dut); one instance per core.
- Accepts single or burst commands from the core on a valid/ready port.
- Drives the req/gnt request channel (core_id, opcode, we, addr, data_in, burst_id).
- Collects read data on rvalid/data_out and returns one response per beat, with timeout/abort reporting.

Parameters:
- AW, 11, address width.
- DW, 8, data width.
- CW, 2, core_id width.
- CORE_ID, 0, constant driven on core_id.
- LW, 4, burst length field width; beats = cmd_len+1, 1..16.
- TO_CYCLES, 64, timeout limit for a wait in REQ or WAIT_R.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  initiator can accept a command
- cmd_we  in  1  1=write burst, 0=read burst
- cmd_opcode  in  2  opcode forwarded on every beat
- cmd_addr  in  AW  start address
- cmd_wdata  in  DW  base write data
- cmd_len  in  LW  beats-1
- core_id  out  CW  constant CORE_ID
- opcode  out  2  latched cmd_opcode
- req  out  1  request valid
- gnt  in  1  grant from mp_dut
- we  out  1  latched cmd_we
- addr  out  AW  current beat address
- data_in  out  DW  current beat write data
- rvalid  in  1  read data valid
- data_out  in  DW  read data
- burst_id  out  32  tag of the current burst
- rsp_valid  out  1  one-cycle pulse, beat finished
- rsp_data  out  DW  read data; 0 for writes and errors
- rsp_last  out  1  final response of the command
- rsp_err  out  1  timeout abort
- busy  out  1  state != IDLE

Behaviour:

Reset (rst_n=0 at a clk edge):
- State -> IDLE.
- All outputs 0 except cmd_ready=1 and core_id=CORE_ID.
- burst_id=0; beat and timeout counters cleared.
- Reset mid-burst aborts the burst with no response pulse.

States: IDLE, REQ, WAIT_R.

IDLE:
- cmd_ready=1.
- On cmd_valid: latch we, opcode, addr, wdata, len; beat=0; burst_id increments.
  - The first accepted command after reset carries burst_id=1.
- Go to REQ on the next cycle. No combinational path from cmd_valid to req.

REQ:
- req=1; opcode, we, addr and data_in are held stable until the handshake.
- Handshake = the clk edge with req=1 and gnt=1.
- data_in = wdata + beat, mod 2^DW.
- addr = start + beat, mod 2^AW (wraps 0x7FF -> 0x000).
- Write handshake:
  - rsp_valid pulses next cycle with rsp_data=0 and rsp_last=(beat==len).
  - If last beat, go to IDLE (req drops).
  - Otherwise beat++ and stay in REQ with req held high, so back-to-back beats are possible.
- Read handshake:
  - req drops next cycle; go to WAIT_R.

WAIT_R:
- On rvalid: rsp_valid=1 next cycle, rsp_data=data_out, rsp_last=(beat==len).
- If last beat, go to IDLE; otherwise beat++ and go to REQ.
- rvalid arriving in IDLE or REQ is ignored.
- rvalid in the same cycle as the gnt that completes a read handshake is also ignored; read data is earliest one cycle after the handshake.

Timeout:
- The counter resets on entering REQ or WAIT_R and on every handshake/rvalid.
- If it reaches TO_CYCLES with no progress:
  - one rsp_valid pulse with rsp_err=1, rsp_last=1, rsp_data=0;
  - req=0; remaining beats dropped; go to IDLE.

General:
- cmd_ready=0 in every state except IDLE.
- Exactly len+1 rsp_valid pulses per command, or fewer ending with an error pulse.
- burst_id is stable for the whole burst and increments once per command, wrapping at 2^32.

Test Plan:
1. Single write: cmd_we=1, addr=0x010, wdata=0x5A, len=0, gnt high one cycle after req -> one handshake with addr=0x010, data_in=0x5A, burst_id=1; rsp_valid/rsp_last=1; back to IDLE; cmd_ready=1.
2. 4-beat read: addr=0x100, len=3, rvalid 2 cycles after each gnt with data 0x11..0x44 -> addrs 0x100..0x103; rsp_data 0x11, 0x22, 0x33, 0x44; rsp_last only on 0x44.
3. Write burst with wrap: addr=0x7FE, len=2, wdata=0xFF, gnt held high -> addrs 0x7FE, 0x7FF, 0x000; data 0xFF, 0x00, 0x01; req high continuously 3 cycles.
4. Gnt stall: gnt low 10 cycles then high -> req, addr and data_in unchanged across all 10 stall cycles; a single handshake occurs.
5. Timeout: read, gnt granted, rvalid never asserted -> after 64 cycles a single rsp_valid with rsp_err=1, rsp_last=1; IDLE; next command gets burst_id+1.
6. Reset mid-burst: rst_n=0 during beat 2 of an 8-beat read -> req=0, busy=0, burst_id=0 the next cycle; no rsp_valid; stray rvalid afterward ignored.

Source files
------------

// File: rtl/mp_core_initiator.sv
// mp_core_initiator
//   Per-core request initiator for the multiprocessor memory subsystem.
//   It takes single or burst commands from the core, drives one req/gnt
//   transaction per beat, collects read data, and returns one response
//   per beat. A wait that makes no progress for TO_CYCLES cycles aborts
//   the rest of the burst with an error response.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid / cmd_ready      command handshake from the core
//   cmd_we, cmd_opcode         burst direction and opcode
//   cmd_addr, cmd_wdata        start address and base write data
//   cmd_len                    number of beats minus one
//   core_id                    constant CORE_ID
//   opcode, we, addr, data_in  request fields for the current beat
//   req / gnt                  request channel handshake
//   rvalid, data_out           read data return
//   burst_id                   tag of the current burst (first is 1)
//   rsp_valid, rsp_data        one-cycle response per finished beat
//   rsp_last, rsp_err          final response / timeout abort
//   busy                       high whenever not idle
module mp_core_initiator #(
    parameter int unsigned AW        = 11,
    parameter int unsigned DW        = 8,
    parameter int unsigned CW        = 2,
    parameter int unsigned CORE_ID   = 0,
    parameter int unsigned LW        = 4,
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [1:0]    cmd_opcode,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [LW-1:0] cmd_len,
    output logic [CW-1:0] core_id,
    output logic [1:0]    opcode,
    output logic          req,
    input  logic          gnt,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_in,
    input  logic          rvalid,
    input  logic [DW-1:0] data_out,
    output logic [31:0]   burst_id,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          rsp_err,
    output logic          busy
);

    localparam int unsigned TW = $clog2(TO_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    opcode_q, opcode_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [TW-1:0] to_q, to_d;
    logic [31:0]   bid_q, bid_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_last_q, rsp_last_d;
    logic          rsp_err_q, rsp_err_d;

    logic last_beat;
    logic timed_out;

    assign last_beat = (beat_q == len_q);
    // Counter holds the number of idle cycles already spent; the edge that
    // would complete the TO_CYCLES-th idle cycle is the abort edge.
    assign timed_out = (to_q == TW'(TO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            opcode_q    <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            to_q        <= '0;
            bid_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            opcode_q    <= opcode_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            to_q        <= to_d;
            bid_q       <= bid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        opcode_d    = opcode_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        beat_d      = beat_q;
        to_d        = to_q;
        bid_d       = bid_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d     = cmd_we;
                    opcode_d = cmd_opcode;
                    base_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    len_d    = cmd_len;
                    beat_d   = '0;
                    to_d     = '0;
                    bid_d    = bid_q + 32'd1;
                    state_d  = REQ;
                end
            end

            REQ: begin
                if (gnt) begin
                    to_d = '0;
                    if (we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_last_d  = last_beat;
                        if (last_beat) begin
                            state_d = IDLE;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (timed_out) begin
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end

            WAIT_R: begin
                if (rvalid) begin
                    to_d        = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = data_out;
                    rsp_last_d  = last_beat;
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = REQ;
                    end
                end else if (timed_out) begin
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign req       = (state_q == REQ);
    assign core_id   = CW'(CORE_ID);
    assign opcode    = opcode_q;
    assign we        = we_q;
    assign addr      = base_q + AW'(beat_q);
    assign data_in   = wdata_q + DW'(beat_q);
    assign burst_id  = bid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mp_core_initiator.sv
// Testbench for mp_core_initiator: directed scenarios with a queue-based
// model of expected request beats and responses.
module tb_mp_core_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [1:0]  cmd_opcode = '0;
    logic [10:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic [3:0]  cmd_len = '0;
    logic [1:0]  core_id;
    logic [1:0]  opcode;
    logic        req;
    logic        gnt = 1'b0;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  data_in;
    logic        rvalid = 1'b0;
    logic [7:0]  data_out = '0;
    logic [31:0] burst_id;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        busy;

    mp_core_initiator #(
        .AW(11), .DW(8), .CW(2), .CORE_ID(2), .LW(4), .TO_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_len(cmd_len), .core_id(core_id), .opcode(opcode), .req(req),
        .gnt(gnt), .we(we), .addr(addr), .data_in(data_in), .rvalid(rvalid),
        .data_out(data_out), .burst_id(burst_id), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
        logic [31:0] bid;
        logic        we;
        logic [1:0]  op;
    } hs_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       err;
    } rsp_t;

    hs_t  hs_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int rsp_cyc = 0;
    int hs_count = 0;
    int req_hi_cnt = 0;
    logic [31:0] exp_bid = '0;

    logic [10:0] last_hs_addr;
    logic [7:0]  last_hs_data;
    logic [31:0] last_hs_bid;
    logic [7:0]  last_rsp_data;
    logic        last_rsp_last;
    logic        last_rsp_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the expectation queues.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst_n) begin
                chk("core_id", core_id, 2'd2);
                chk("ready_vs_busy", cmd_ready, !busy);
                if (req) begin
                    req_hi_cnt++;
                    chk("req_expected", hs_q.size() != 0, 1);
                    if (hs_q.size() != 0) begin
                        chk("hs_addr", addr, hs_q[0].addr);
                        chk("hs_data_in", data_in, hs_q[0].data);
                        chk("hs_burst_id", burst_id, hs_q[0].bid);
                        chk("hs_we", we, hs_q[0].we);
                        chk("hs_opcode", opcode, hs_q[0].op);
                        if (gnt) begin
                            last_hs_addr = addr;
                            last_hs_data = data_in;
                            last_hs_bid  = burst_id;
                            hs_cyc = cyc;
                            hs_count++;
                            void'(hs_q.pop_front());
                        end
                    end
                end
                if (rsp_valid) begin
                    chk("rsp_expected", rsp_q.size() != 0, 1);
                    if (rsp_q.size() != 0) begin
                        chk("rsp_data", rsp_data, rsp_q[0].data);
                        chk("rsp_last", rsp_last, rsp_q[0].last);
                        chk("rsp_err", rsp_err, rsp_q[0].err);
                        last_rsp_data = rsp_data;
                        last_rsp_last = rsp_last;
                        last_rsp_err  = rsp_err;
                        rsp_cyc = cyc;
                        void'(rsp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Offers one command; the model expands it into per-beat request fields
    // and, for writes, into the per-beat responses.
    task automatic issue(input logic w, input logic [1:0] op, input logic [10:0] a,
                         input logic [7:0] d, input logic [3:0] l);
        hs_t  h;
        rsp_t r;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        exp_bid = exp_bid + 1;
        for (int k = 0; k <= int'(l); k++) begin
            h.addr = a + 11'(k);
            h.data = d + 8'(k);
            h.bid  = exp_bid;
            h.we   = w;
            h.op   = op;
            hs_q.push_back(h);
            if (w) begin
                r.data = '0;
                r.last = (k == int'(l));
                r.err  = 1'b0;
                rsp_q.push_back(r);
            end
        end
        cmd_we = w; cmd_opcode = op; cmd_addr = a; cmd_wdata = d; cmd_len = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we = ~w; cmd_opcode = ~op; cmd_addr = ~a; cmd_wdata = ~d; cmd_len = ~l;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_req_seen"}, req, 1);
    endtask

    task automatic push_rsp(input logic [7:0] d, input logic last, input logic err);
        rsp_t r;
        r.data = d; r.last = last; r.err = err;
        rsp_q.push_back(r);
    endtask

    task automatic finish_test(input string nm);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle"}, busy, 0);
        repeat (2) @(negedge clk);
        #3;
        chk({nm, "_cmd_ready"}, cmd_ready, 1);
        chk({nm, "_hs_left"}, hs_q.size(), 0);
        chk({nm, "_rsp_left"}, rsp_q.size(), 0);
    endtask

    initial begin
        int base_req;
        int base_hs;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_burst_id", burst_id, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_we", we, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_core_id", core_id, 2'd2);
        rst_n = 1'b1;

        // 1: single write, grant one cycle after req
        issue(1'b1, 2'b01, 11'h010, 8'h5A, 4'd0);
        wait_req("t1");
        @(negedge clk); gnt = 1'b1;
        @(negedge clk); gnt = 1'b0;
        finish_test("t1");
        chk("t1_hs_addr", last_hs_addr, 11'h010);
        chk("t1_hs_data", last_hs_data, 8'h5A);
        chk("t1_hs_bid", last_hs_bid, 1);
        chk("t1_rsp_last", last_rsp_last, 1);

        // 2: 4-beat read, data two cycles after each grant; the rvalid
        // coinciding with the first grant must be ignored
        issue(1'b0, 2'b10, 11'h100, 8'h00, 4'd3);
        for (int k = 0; k < 4; k++) begin
            wait_req("t2");
            gnt = 1'b1;
            if (k == 0) begin rvalid = 1'b1; data_out = 8'hEE; end
            @(negedge clk); gnt = 1'b0; rvalid = 1'b0;
            @(negedge clk);
            rvalid = 1'b1;
            data_out = 8'(8'h11 * (k + 1));
            push_rsp(data_out, k == 3, 1'b0);
            @(negedge clk); rvalid = 1'b0;
        end
        finish_test("t2");
        chk("t2_hs_addr", last_hs_addr, 11'h103);
        chk("t2_rsp_data", last_rsp_data, 8'h44);
        chk("t2_rsp_last", last_rsp_last, 1);

        // 3: write burst wrapping the address space, grant held high
        gnt = 1'b1;
        base_req = req_hi_cnt;
        issue(1'b1, 2'b01, 11'h7FE, 8'hFF, 4'd2);
        finish_test("t3");
        gnt = 1'b0;
        chk("t3_req_cycles", req_hi_cnt - base_req, 3);
        chk("t3_hs_addr", last_hs_addr, 11'h000);
        chk("t3_hs_data", last_hs_data, 8'h01);
        chk("t3_hs_bid", last_hs_bid, 3);

        // 4: grant stalled for 10 cycles
        base_hs = hs_count;
        issue(1'b1, 2'b11, 11'h3A5, 8'h80, 4'd0);
        wait_req("t4");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_stall_req", req, 1);
            chk("t4_stall_addr", addr, 11'h3A5);
            chk("t4_stall_data", data_in, 8'h80);
        end
        gnt = 1'b1;
        @(negedge clk); gnt = 1'b0;
        finish_test("t4");
        chk("t4_handshakes", hs_count - base_hs, 1);

        // 5: read granted, data never returns
        issue(1'b0, 2'b00, 11'h020, 8'h00, 4'd1);
        wait_req("t5");
        gnt = 1'b1;
        @(negedge clk); gnt = 1'b0;
        push_rsp(8'h00, 1'b1, 1'b1);
        n = 0;
        while (rsp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_rsp_seen", rsp_q.size(), 0);
        chk("t5_timeout_latency", rsp_cyc - hs_cyc, 65);
        chk("t5_rsp_err", last_rsp_err, 1);
        chk("t5_dropped_beats", hs_q.size(), 1);
        hs_q.delete();
        finish_test("t5");

        // 6: reset during beat 2 of an 8-beat read
        issue(1'b0, 2'b01, 11'h200, 8'h00, 4'd7);
        for (int k = 0; k < 2; k++) begin
            wait_req("t6");
            gnt = 1'b1;
            @(negedge clk);
            gnt = 1'b0;
            rvalid = 1'b1;
            data_out = 8'(8'hA0 + k);
            push_rsp(data_out, 1'b0, 1'b0);
            @(negedge clk); rvalid = 1'b0;
            if (k == 0) chk("t6_hs_bid", last_hs_bid, 6);
        end
        wait_req("t6b2");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        hs_q.delete();
        rsp_q.delete();
        exp_bid = '0;
        chk("t6_rst_req", req, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_bid", burst_id, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rvalid = 1'b1; data_out = 8'h99;
        repeat (3) @(negedge clk);
        rvalid = 1'b0;
        gnt = 1'b1;
        issue(1'b1, 2'b10, 11'h001, 8'h10, 4'd1);
        finish_test("t6");
        gnt = 1'b0;
        chk("t6_new_bid", last_hs_bid, 1);
        chk("t6_new_addr", last_hs_addr, 11'h002);
        chk("t6_new_data", last_hs_data, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
